// File: rtl/paper_pkg.sv
// Shared types and default widths for the fetch sequencer.
package paper_pkg;
  localparam int ADDR_W_DEF  = 2;
  localparam int INSTR_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: sync reset to RESET_PC, jump load has priority over
// increment, and a one-cycle wrap flag registered off the 2**ADDR_W-1 -> 0 step.
module pc_counter #(
  parameter int                ADDR_W   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_wrap
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_wrap;

  // PC update; wrap is only ever high for the cycle after a wrapping increment
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_load) begin
        r_pc <= i_load_val;
      end else if (i_inc) begin
        r_pc   <= r_pc + ADDR_W'(1);
        r_wrap <= &r_pc;
      end
    end
  end

  assign o_pc   = r_pc;
  assign o_wrap = r_wrap;
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, captures RAM data into the IR and
// hands it downstream over valid/ready.
// Optional build macro FETCH_PREFETCH_EN: on a plain ISSUE handshake the IR
// reloads from the current PC in the same cycle (1 instruction/cycle).
module fetch_sequencer
  import paper_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [INSTR_W-1:0] ram_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               pc_wrap
);
  fetch_state_t       r_state;
  fetch_state_t       w_next_state;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [ADDR_W-1:0]  w_pc;
  logic               w_hs;
  logic               w_capture;

  // Handshake only exists while the IR is presented
  assign w_hs = (r_state == ISSUE) && instr_ready;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .i_load     (jump_valid),
    .i_load_val (jump_addr),
    .i_inc      (w_capture),
    .o_pc       (w_pc),
    .o_wrap     (pc_wrap)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: jump beats halt beats handshake
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (!jump_valid && start) w_next_state = FETCH;
      end
      FETCH: begin
        if (jump_valid) w_next_state = FETCH;
        else if (halt)  w_next_state = IDLE;
        else            w_next_state = ISSUE;
      end
      ISSUE: begin
        if (jump_valid) w_next_state = FETCH;
        else if (w_hs) begin
          if (halt) w_next_state = IDLE;
`ifdef FETCH_PREFETCH_EN
          else      w_next_state = ISSUE;
`else
          else      w_next_state = FETCH;
`endif
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs and the capture strobe (capture always implies a PC increment)
  always_comb begin
    busy        = (r_state != IDLE);
    instr_valid = (r_state == ISSUE);
    w_capture   = 1'b0;
    if (!jump_valid && !halt) begin
      if (r_state == FETCH) w_capture = 1'b1;
`ifdef FETCH_PREFETCH_EN
      if (w_hs)             w_capture = 1'b1;
`endif
    end
  end

  // Instruction register and the address it came from
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= ram_data;
      r_instr_pc <= w_pc;
    end
  end

  assign ram_addr = w_pc;
  assign instr    = r_instr;
  assign instr_pc = r_instr_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a cycle-level reference model predicts state,
// issued words are queued at stimulus time and checked by a separate monitor.
module tb_fetch_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, halt = 1'b0, jump_valid = 1'b0, instr_ready = 1'b0;
  logic [1:0] jump_addr = '0;
  logic [1:0] ram_addr, instr, instr_pc, ram_data;
  logic       instr_valid, busy, pc_wrap;
  logic [1:0] ram [DEPTH];

  assign ram_data = ram[ram_addr];

  fetch_sequencer #(.ADDR_W(2), .INSTR_W(2), .RESET_PC(2'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .ram_addr(ram_addr),
    .ram_data(ram_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
    .pc_wrap(pc_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, wrap_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] log_q[$];

  // Reference model: running flag, word-held flag, PC and held word
  int m_pc = 0, m_busy = 0, m_valid = 0, m_ir = 0, m_ipc = 0, m_wrap = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void load_word();
    m_ir    = int'(ram[m_pc]);
    m_ipc   = m_pc;
    m_wrap  = (m_pc == DEPTH-1) ? 1 : 0;
    m_pc    = (m_pc + 1) % DEPTH;
    m_valid = 1;
  endfunction

  function automatic void model_step(input logic s, h, j, input logic [1:0] ja,
                                     input logic r, rs);
    m_wrap = 0;
    if (rs) begin
      m_pc = 0; m_busy = 0; m_valid = 0; m_ir = 0; m_ipc = 0;
    end else if (m_busy == 0) begin
      if (j)      m_pc = int'(ja);
      else if (s) m_busy = 1;
    end else if (j) begin
      m_pc = int'(ja); m_valid = 0;
    end else if (m_valid == 0) begin
      if (h) m_busy = 0;
      else   load_word();
    end else if (r) begin
      if (h) begin
        m_busy = 0; m_valid = 0;
      end else begin
`ifdef FETCH_PREFETCH_EN
        load_word();
`else
        m_valid = 0;
`endif
      end
    end
  endfunction

  // One clock: drive, predict any handshake, advance model, compare state
  task automatic cyc(input logic s, h, j, input logic [1:0] ja, input logic r, rs);
    start = s; halt = h; jump_valid = j; jump_addr = ja; instr_ready = r; reset = rs;
    if (!rs && m_busy == 1 && m_valid == 1 && r)
      exp_q.push_back({m_ir[1:0], m_ipc[1:0]});
    @(posedge clk); #1;
    model_step(s, h, j, ja, r, rs);
    if (pc_wrap) wrap_cnt++;
    chk("busy", int'(busy), m_busy);
    chk("instr_valid", int'(instr_valid), m_valid);
    chk("pc", int'(ram_addr), m_pc);
    chk("pc_wrap", int'(pc_wrap), m_wrap);
    chk("instr", int'(instr), m_ir);
    chk("instr_pc", int'(instr_pc), m_ipc);
  endtask

  // Monitor: every DUT handshake must match the oldest predicted issue
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      logic [3:0] e;
      log_q.push_back({instr, instr_pc});
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL issue_unexpected actual=%0d@pc%0d expected=none", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("issue_instr", int'(instr), int'(e[3:2]));
        chk("issue_pc", int'(instr_pc), int'(e[1:0]));
      end
    end
  end

  task automatic run_issues(input int n, input int bound);
    int target;
    target = log_q.size() + n;
    for (int i = 0; i < bound; i++) begin
      if (log_q.size() >= target) break;
      cyc(0, 0, 0, 2'd0, 1, 0);
    end
    chk("issue_count", log_q.size(), target);
  endtask

  task automatic run_until_valid();
    for (int i = 0; i < 8; i++) begin
      if (m_valid == 1) break;
      cyc(0, 0, 0, 2'd0, 0, 0);
    end
    chk("reached_issue", int'(instr_valid), 1);
  endtask

  function automatic int word(input int d, input int p);
    return d * 4 + p;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 2'(i);
    cyc(0, 0, 0, 2'd0, 0, 1);
    cyc(0, 0, 0, 2'd0, 0, 1);

    // 1: free run, five issues across the wrap
    log_q.delete(); wrap_cnt = 0;
    cyc(1, 0, 0, 2'd0, 1, 0);
    run_issues(5, 20);
    for (int k = 0; k < 5 && k < log_q.size(); k++)
      chk("s1_word", int'(log_q[k]), word(k % 4, k % 4));
    chk("s1_wrap_count", wrap_cnt, 1);

    // 2: back-pressure holds the presented word
    run_until_valid();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 2'd0, 0, 0);

    // 3: jump coinciding with the handshake of pc 0
    cyc(0, 0, 0, 2'd0, 0, 1);
    cyc(1, 0, 0, 2'd0, 0, 0);
    run_until_valid();
    log_q.delete();
    cyc(0, 0, 1, 2'd2, 1, 0);
    run_issues(1, 10);
    if (log_q.size() >= 2) begin
      chk("s3_first", int'(log_q[0]), word(0, 0));
      chk("s3_after_jump", int'(log_q[1]), word(2, 2));
    end

    // 4: halt waits for the handshake, then start resumes
    run_until_valid();
    cyc(0, 1, 0, 2'd0, 0, 0);
    cyc(0, 1, 0, 2'd0, 0, 0);
    cyc(0, 1, 0, 2'd0, 1, 0);
    cyc(0, 0, 0, 2'd0, 0, 0);
    chk("s4_idle", int'(busy), 0);
    cyc(1, 0, 0, 2'd0, 0, 0);
    run_issues(2, 10);

    // 5: reset while a word is presented
    run_until_valid();
    cyc(0, 0, 0, 2'd0, 1, 1);
    chk("s5_pc_after_reset", int'(ram_addr), 0);
    log_q.delete();
    cyc(1, 0, 0, 2'd0, 1, 0);
    run_issues(1, 10);
    if (log_q.size() >= 1) chk("s5_first", int'(log_q[0]), word(0, 0));

    // 6: jump while idle, then start from pc 3 through the wrap
    cyc(0, 0, 0, 2'd0, 0, 1);
    cyc(0, 0, 1, 2'd3, 0, 0);
    log_q.delete(); wrap_cnt = 0;
    cyc(1, 0, 0, 2'd0, 1, 0);
    run_issues(2, 10);
    if (log_q.size() >= 2) begin
      chk("s6_first", int'(log_q[0]), word(3, 3));
      chk("s6_second", int'(log_q[1]), word(0, 0));
    end
    chk("s6_wrap_count", wrap_cnt, 1);

    // Randomized traffic with random RAM contents
    for (int i = 0; i < DEPTH; i++) ram[i] = 2'($urandom_range(3));
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(99) < 30, $urandom_range(99) < 10,
          $urandom_range(99) < 8, 2'($urandom_range(3)),
          $urandom_range(99) < 60, $urandom_range(99) < 2);

    cyc(0, 0, 0, 2'd0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
